// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage.
package cpu_pkg;

    localparam int W = 8;
    localparam int IW = 9;
    localparam logic [IW-1:0] HALT_OP = 9'h1FF;
    localparam logic [IW-1:0] NOP_OP = 9'h000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_rom.sv
// Synchronous-read instruction memory with a write port.
// The read is gated by an enable so the registered output doubles as the
// instruction field of the fetch/decode register and simply holds when
// the enable is low. The read returns old data when it hits the address
// being written in the same cycle. No reset, so a vendor RAM can drop in.
module instr_rom
    import cpu_pkg::*;
#(
    parameter int AW = W,
    parameter int DW = IW
) (
    input  logic          Clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port and enabled read port; the read sees the pre-write value.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads the instruction memory at PC and holds the result in
// the fetch/decode register with its PC and a valid bit. Handles stall,
// flush and HALT detection (Done is sticky until Reset).
//
// Handshake: there is no ready/valid pair here. Valid marks Instr/InstrPC
// as a live instruction. Stall holds all three. Flush clears Valid while
// still loading. Once HALT has been seen valid, Valid stays low until Reset.
//
// The memory output register cannot be reset. A separate nop_sel flag
// forces Instr to NOP_OP after reset until the first real load.
module instr_fetch
    import cpu_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    input  logic [W-1:0]  PC,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          LoadEn,
    input  logic [W-1:0]  LoadAddr,
    input  logic [IW-1:0] LoadData,
    output logic [IW-1:0] Instr,
    output logic [W-1:0]  InstrPC,
    output logic          Valid,
    output logic          Done
);

    fetch_state_t  state;
    fetch_state_t  next_state;
    logic          halting;
    logic          load;
    logic          nop_sel;
    logic [IW-1:0] rom_data;

    instr_rom #(
        .AW (W),
        .DW (IW)
    ) u_rom (
        .Clk     (Clk),
        .rd_en   (load),
        .rd_addr (PC),
        .rd_data (rom_data),
        .wr_en   (LoadEn),
        .wr_addr (LoadAddr),
        .wr_data (LoadData)
    );

    assign Instr = nop_sel ? NOP_OP : rom_data;
    assign Done  = (state == HALTED);

    // Next-state logic. HALT detection is treated as already halted for
    // the register update, so HALT is shown valid for exactly one cycle.
    // The load enable is derived here as well.
    always_comb begin
        next_state = state;
        halting    = 1'b0;
        load       = 1'b0;
        if (state == RUN && Valid && Instr == HALT_OP && !Flush) begin
            halting    = 1'b1;
            next_state = HALTED;
        end
        if (!Reset && state == RUN && !halting && (Flush || !Stall)) begin
            load = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Fetch/decode register: PC, valid and NOP override. Priority order is
    // halt, flush, stall, then a normal load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            InstrPC <= '0;
            Valid   <= 1'b0;
            nop_sel <= 1'b1;
        end else if (state == HALTED || halting) begin
            Valid <= 1'b0;
        end else if (Flush) begin
            InstrPC <= PC;
            Valid   <= 1'b0;
            nop_sel <= 1'b0;
        end else if (!Stall) begin
            InstrPC <= PC;
            Valid   <= 1'b1;
            nop_sel <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a reference model predicts the
// outputs for each cycle. The prediction is queued when the inputs are
// driven and compared after the clock edge.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic          Clk;
    logic          Reset;
    logic [W-1:0]  PC;
    logic          Stall;
    logic          Flush;
    logic          LoadEn;
    logic [W-1:0]  LoadAddr;
    logic [IW-1:0] LoadData;
    logic [IW-1:0] Instr;
    logic [W-1:0]  InstrPC;
    logic          Valid;
    logic          Done;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected output word: {done, valid, instr_pc, instr}
    localparam int EW = 2 + W + IW;
    logic [EW-1:0] exp_q[$];

    // Reference model state
    logic [IW-1:0] m_mem [0:(1<<W)-1];
    logic [IW-1:0] m_instr;
    logic [W-1:0]  m_pc;
    logic          m_valid;
    logic          m_done;

    instr_fetch dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .PC       (PC),
        .Stall    (Stall),
        .Flush    (Flush),
        .LoadEn   (LoadEn),
        .LoadAddr (LoadAddr),
        .LoadData (LoadData),
        .Instr    (Instr),
        .InstrPC  (InstrPC),
        .Valid    (Valid),
        .Done     (Done)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model one posedge with the given inputs.
    task automatic model_step(input logic rst, input logic [W-1:0] pc, input logic stall,
                              input logic flush, input logic ld, input logic [W-1:0] la,
                              input logic [IW-1:0] ldat);
        logic [IW-1:0] rd;
        logic          halt_now;
        rd = m_mem[pc];
        if (rst) begin
            m_instr = NOP_OP;
            m_pc    = '0;
            m_valid = 1'b0;
            m_done  = 1'b0;
        end else begin
            halt_now = !m_done && m_valid && (m_instr == HALT_OP) && !flush;
            if (m_done || halt_now) begin
                m_valid = 1'b0;
                m_done  = 1'b1;
            end else if (flush) begin
                m_instr = rd;
                m_pc    = pc;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = rd;
                m_pc    = pc;
                m_valid = 1'b1;
            end
        end
        if (ld) m_mem[la] = ldat;
    endtask

    // Drive one cycle, queue the prediction, then compare after the edge.
    task automatic cycle(input logic rst, input logic [W-1:0] pc, input logic stall,
                         input logic flush, input logic ld, input logic [W-1:0] la,
                         input logic [IW-1:0] ldat);
        logic [EW-1:0] e;
        @(negedge Clk);
        Reset    = rst;
        PC       = pc;
        Stall    = stall;
        Flush    = flush;
        LoadEn   = ld;
        LoadAddr = la;
        LoadData = ldat;
        model_step(rst, pc, stall, flush, ld, la, ldat);
        exp_q.push_back({m_done, m_valid, m_pc, m_instr});
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        check("instr",    32'(Instr),   32'(e[IW-1:0]));
        check("instr_pc", 32'(InstrPC), 32'(e[IW +: W]));
        check("valid",    32'(Valid),   32'(e[IW+W]));
        check("done",     32'(Done),    32'(e[IW+W+1]));
    endtask

    task automatic run(input logic [W-1:0] pc, input logic stall, input logic flush);
        cycle(1'b0, pc, stall, flush, 1'b0, '0, '0);
    endtask

    initial begin
        logic [IW-1:0] d;
        Reset = 1'b1; PC = '0; Stall = 1'b0; Flush = 1'b0;
        LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
        m_instr = NOP_OP; m_pc = '0; m_valid = 1'b0; m_done = 1'b0;

        // Load the whole memory while held in reset; also checks reset values.
        for (int a = 0; a < (1 << W); a++) begin
            case (a)
                0: d = 9'h011;
                1: d = 9'h022;
                2: d = 9'h033;
                3: d = 9'h044;
                4: d = 9'h055;
                5: d = 9'h066;
                6: d = HALT_OP;
                default: d = IW'($urandom_range(1, 9'h1FE));
            endcase
            cycle(1'b1, '0, 1'b0, 1'b0, 1'b1, W'(a), d);
        end
        check("reset_instr", 32'(Instr), 32'h000);
        check("reset_valid", 32'(Valid), 32'h0);

        // Basic fetch
        for (int p = 0; p < 4; p++) run(W'(p), 1'b0, 1'b0);
        check("fetch3_instr", 32'(Instr), 32'h044);
        check("fetch3_pc", 32'(InstrPC), 32'h3);

        // Stall holds, release loads current PC
        run(8'd2, 1'b0, 1'b0);
        run(8'd3, 1'b1, 1'b0);
        run(8'd4, 1'b1, 1'b0);
        check("stall_instr", 32'(Instr), 32'h033);
        check("stall_valid", 32'(Valid), 32'h1);
        run(8'd4, 1'b0, 1'b0);
        check("unstall_instr", 32'(Instr), 32'h055);

        // Flush beats stall; flush alone kills one cycle
        run(8'd5, 1'b1, 1'b1);
        check("flush_pc", 32'(InstrPC), 32'h5);
        check("flush_valid", 32'(Valid), 32'h0);
        run(8'd0, 1'b0, 1'b0);
        run(8'd1, 1'b0, 1'b1);
        run(8'd2, 1'b0, 1'b0);
        check("after_flush_valid", 32'(Valid), 32'h1);

        // Halt
        run(8'd6, 1'b0, 1'b0);
        check("halt_instr", 32'(Instr), 32'h1FF);
        run(8'd7, 1'b0, 1'b0);
        check("halt_done", 32'(Done), 32'h1);
        check("halt_valid", 32'(Valid), 32'h0);
        run(8'd8, 1'b0, 1'b0);

        // Reset while halted, with a load to addr 7
        cycle(1'b1, '0, 1'b0, 1'b0, 1'b1, 8'd7, 9'h0AB);
        check("rst_done", 32'(Done), 32'h0);

        // Flushed halt
        run(8'd6, 1'b0, 1'b0);
        run(8'd9, 1'b0, 1'b1);
        run(8'd10, 1'b0, 1'b0);
        check("flushed_halt_done", 32'(Done), 32'h0);

        // Load during reset, then read-before-write on the same address
        run(8'd7, 1'b0, 1'b0);
        check("load_rst_instr", 32'(Instr), 32'h0AB);
        cycle(1'b0, 8'd7, 1'b0, 1'b0, 1'b1, 8'd7, 9'h0CD);
        check("rbw_old", 32'(Instr), 32'h0AB);
        run(8'd7, 1'b0, 1'b0);
        check("rbw_new", 32'(Instr), 32'h0CD);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0),
                  W'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  W'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) == 0) ? HALT_OP : IW'($urandom_range(0, 9'h1FE)));
        end

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
